// File: rtl/pb_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a counter-qualified
// four-state FSM. Produces a clean active-low level, one-cycle press/release
// strobes and a saturating count of aborted transitions for bring-up.
module pb_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES),
    parameter int GLITCH_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PB,
    input  logic                clr_glitch,
    output logic                PB_db,
    output logic                pressed,
    output logic                released,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_HI,
        WAIT_LO,
        STABLE_LO,
        WAIT_HI
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    state_t              state_q, state_d;
    logic                syncFf1_q, syncFf2_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                pbDb_q, pbDb_d;
    logic                pressed_q, pressed_d;
    logic                released_q, released_d;
    logic [GLITCH_W-1:0] glitchCnt_q, glitchCnt_d;
    logic                glitchHit;

    // Two-flop synchronizer; reset to the released level so a reset never fakes a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncFf1_q <= 1'b1;
            syncFf2_q <= 1'b1;
        end else begin
            syncFf1_q <= PB;
            syncFf2_q <= syncFf1_q;
        end
    end

    // Next-state logic: a WAIT state accepts only after an uninterrupted run, any bounce aborts.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pbDb_d     = pbDb_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        glitchHit  = 1'b0;
        case (state_q)
            STABLE_HI: begin
                if (!syncFf2_q) begin
                    state_d = WAIT_LO;
                    count_d = '0;
                end
            end
            WAIT_LO: begin
                if (syncFf2_q) begin
                    state_d   = STABLE_HI;
                    count_d   = '0;
                    glitchHit = 1'b1;
                end else if (count_q == CNT_LAST) begin
                    state_d   = STABLE_LO;
                    count_d   = '0;
                    pbDb_d    = 1'b0;
                    pressed_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            STABLE_LO: begin
                if (syncFf2_q) begin
                    state_d = WAIT_HI;
                    count_d = '0;
                end
            end
            WAIT_HI: begin
                if (!syncFf2_q) begin
                    state_d   = STABLE_LO;
                    count_d   = '0;
                    glitchHit = 1'b1;
                end else if (count_q == CNT_LAST) begin
                    state_d    = STABLE_HI;
                    count_d    = '0;
                    pbDb_d     = 1'b1;
                    released_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_HI;
                count_d = '0;
                pbDb_d  = 1'b1;
            end
        endcase
    end

    // Glitch counter: clear wins over a same-cycle abort, and it sticks at all-ones.
    always_comb begin
        glitchCnt_d = glitchCnt_q;
        if (clr_glitch) begin
            glitchCnt_d = '0;
        end else if (glitchHit && (glitchCnt_q != GLITCH_MAX)) begin
            glitchCnt_d = glitchCnt_q + GLITCH_W'(1);
        end
    end

    // State and output registers; reset overrides everything, including a half-qualified run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STABLE_HI;
            count_q     <= '0;
            pbDb_q      <= 1'b1;
            pressed_q   <= 1'b0;
            released_q  <= 1'b0;
            glitchCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pbDb_q      <= pbDb_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            glitchCnt_q <= glitchCnt_d;
        end
    end

    assign PB_db      = pbDb_q;
    assign pressed    = pressed_q;
    assign released   = released_q;
    assign glitch_cnt = glitchCnt_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce: a table of input segments with
// hand-derived end results, a per-cycle scoreboard fed by a run-length
// reference model, and a hand-written latency measurement.
module tb_pb_debounce;

    localparam int DB = 8;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PB = 1'b1;
    logic          clr_glitch = 1'b0;
    logic          PB_db;
    logic          pressed;
    logic          released;
    logic [GW-1:0] glitch_cnt;

    pb_debounce #(
        .DB_CYCLES(DB),
        .GLITCH_W (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PB        (PB),
        .clr_glitch(clr_glitch),
        .PB_db     (PB_db),
        .pressed   (pressed),
        .released  (released),
        .glitch_cnt(glitch_cnt)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    typedef struct {
        logic          db;
        logic          p;
        logic          r;
        logic [GW-1:0] gl;
    } exp_t;

    typedef struct {
        string         name;
        logic          pb;
        logic          clr;
        logic          rs;
        int            n;
        logic          expDb;
        logic [GW-1:0] expGl;
        int            expPress;
        int            expRel;
    } row_t;

    exp_t sbQ[$];
    row_t rows[$];

    int checks = 0;
    int errors = 0;
    int segPress;
    int segRel;

    // Reference model: the level is accepted once the synchronized input has
    // disagreed with it for DB+1 consecutive sampled edges.
    logic          m1, m2, mDb;
    int            mRun;
    logic [GW-1:0] mGl;

    function automatic void addRow(string nm, logic pb, logic clr, logic rs, int n,
                                   logic db, logic [GW-1:0] gl, int np, int nr);
        row_t x;
        x.name = nm; x.pb = pb; x.clr = clr; x.rs = rs; x.n = n;
        x.expDb = db; x.expGl = gl; x.expPress = np; x.expRel = nr;
        rows.push_back(x);
    endfunction

    task automatic modelStep(input logic pb, input logic clr, input logic rs);
        exp_t e;
        logic s;
        logic abort;
        e.p = 1'b0;
        e.r = 1'b0;
        if (rs) begin
            m1 = 1'b1; m2 = 1'b1; mDb = 1'b1; mRun = 0; mGl = '0;
        end else begin
            s = m2;
            abort = 1'b0;
            if (s != mDb) begin
                mRun = mRun + 1;
                if (mRun == DB + 1) begin
                    mDb  = s;
                    e.p  = (s == 1'b0);
                    e.r  = (s == 1'b1);
                    mRun = 0;
                end
            end else begin
                abort = (mRun > 0);
                mRun  = 0;
            end
            if (clr) mGl = '0;
            else if (abort && mGl != {GW{1'b1}}) mGl = mGl + 1'b1;
            m2 = m1;
            m1 = pb;
        end
        e.db = mDb;
        e.gl = mGl;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty at t=%0t", $time);
        end else begin
            e = sbQ.pop_front();
            if (PB_db !== e.db || pressed !== e.p || released !== e.r || glitch_cnt !== e.gl) begin
                errors++;
                $display("[TB] FAIL cycle t=%0t got db=%b p=%b r=%b gl=%0d want db=%b p=%b r=%b gl=%0d",
                         $time, PB_db, pressed, released, glitch_cnt, e.db, e.p, e.r, e.gl);
            end
        end
        if (pressed === 1'b1) segPress++;
        if (released === 1'b1) segRel++;
    endtask

    task automatic applyStimulus(input logic pb, input logic clr, input logic rs);
        @(negedge clk);
        PB = pb;
        clr_glitch = clr;
        rst = rs;
        modelStep(pb, clr, rs);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;

        m1 = 1'b1; m2 = 1'b1; mDb = 1'b1; mRun = 0; mGl = '0;

        // name, pb, clr, rst, cycles, db, glitch, #pressed, #released
        addRow("reset",       1, 0, 1,   2, 1, 2'd0, 0, 0);
        addRow("idle",        1, 0, 0, 100, 1, 2'd0, 0, 0);
        addRow("clean_press", 0, 0, 0,  15, 0, 2'd0, 1, 0);
        addRow("clean_rel",   1, 0, 0,  15, 1, 2'd0, 0, 1);
        addRow("bnc_lo4",     0, 0, 0,   4, 1, 2'd0, 0, 0);
        addRow("bnc_hi3",     1, 0, 0,   3, 1, 2'd1, 0, 0);
        addRow("bnc_lo5",     0, 0, 0,   5, 1, 2'd1, 0, 0);
        addRow("bnc_hi2",     1, 0, 0,   2, 1, 2'd1, 0, 0);
        addRow("bnc_lo_hold", 0, 0, 0,  20, 0, 2'd2, 1, 0);
        addRow("bnc_rel",     1, 0, 0,  15, 1, 2'd2, 0, 1);
        addRow("clr",         1, 1, 0,   3, 1, 2'd0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            addRow("sat_lo",  0, 0, 0,   3, 1, (i == 1) ? 2'd0 : ((i == 2) ? 2'd1 : ((i == 3) ? 2'd2 : 2'd3)), 0, 0);
            addRow("sat_hi",  1, 0, 0,   5, 1, (i == 1) ? 2'd1 : ((i == 2) ? 2'd2 : 2'd3), 0, 0);
        end
        addRow("clr_lo",      0, 0, 0,   3, 1, 2'd3, 0, 0);
        addRow("clr_hi",      1, 0, 0,   2, 1, 2'd3, 0, 0);
        addRow("clr_vs_inc",  1, 1, 0,   1, 1, 2'd0, 0, 0);
        addRow("clr_after",   1, 0, 0,   3, 1, 2'd0, 0, 0);
        addRow("mid_lo6",     0, 0, 0,   6, 1, 2'd0, 0, 0);
        addRow("mid_rst",     0, 0, 1,   1, 1, 2'd0, 0, 0);
        addRow("mid_lo10",    0, 0, 0,  10, 1, 2'd0, 0, 0);
        addRow("mid_lo11th",  0, 0, 0,   1, 0, 2'd0, 1, 0);
        addRow("mid_rel",     1, 0, 0,  15, 1, 2'd0, 0, 1);
        addRow("bnd_lo9",     0, 0, 0,   9, 1, 2'd0, 0, 0);
        addRow("bnd_hi",      1, 0, 0,  15, 1, 2'd0, 1, 1);
        addRow("bnd_lo8",     0, 0, 0,   8, 1, 2'd0, 0, 0);
        addRow("bnd_hi_ab",   1, 0, 0,   5, 1, 2'd1, 0, 0);

        for (int r = 0; r < rows.size(); r++) begin
            segPress = 0;
            segRel   = 0;
            for (int c = 0; c < rows[r].n; c++) begin
                applyStimulus(rows[r].pb, rows[r].clr, rows[r].rs);
            end
            checks++;
            if (PB_db !== rows[r].expDb || glitch_cnt !== rows[r].expGl ||
                segPress != rows[r].expPress || segRel != rows[r].expRel) begin
                errors++;
                $display("[TB] FAIL row %s got db=%b gl=%0d press=%0d rel=%0d want db=%b gl=%0d press=%0d rel=%0d",
                         rows[r].name, PB_db, glitch_cnt, segPress, segRel,
                         rows[r].expDb, rows[r].expGl, rows[r].expPress, rows[r].expRel);
            end
        end

        // Hand-written latency: count edges from the first low sample to PB_db falling
        edges = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            edges++;
        end while (PB_db !== 1'b0 && edges < 40);
        checks++;
        if (edges != DB + 3 || pressed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_latency got edges=%0d pressed=%b want edges=%0d pressed=1",
                     edges, pressed, DB + 3);
        end

        // Hand-written latency for the release direction
        edges = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            edges++;
        end while (PB_db !== 1'b1 && edges < 40);
        checks++;
        if (edges != DB + 3 || released !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_latency got edges=%0d released=%b want edges=%0d released=1",
                     edges, released, DB + 3);
        end

        // Strobe must drop on the following cycle
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if (released !== 1'b0 || pressed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL strobe_drop got p=%b r=%b want p=0 r=0", pressed, released);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
